icmp_stream_arbiter: RTL and testbench
======================================

Name: icmp_stream_arbiter

Overview:
- Packet-granular 2:1 round-robin arbiter that shares a single icmp_reply instance between two Avalon-ST 32-bit packet sources (e.g. two TUN/TAP front ends).
- Once a source is granted, its whole packet passes through, start to end of packet, before the grant can move.
- Sits directly upstream of the ICMP echo responder's stream_in port.
- Reports which source owns the current packet on a channel output.

Parameters:
DATA_WIDTH, 32, stream data width in bits
EMPTY_WIDTH, 2, width of the empty field (log2 of DATA_WIDTH/8)

Ports:
clk  input  1  single clock
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in0_data  input  DATA_WIDTH  source 0 data
in0_empty  input  EMPTY_WIDTH  source 0 empty bytes on last beat
in0_valid  input  1  source 0 valid
in0_startofpacket  input  1  source 0 SOP
in0_endofpacket  input  1  source 0 EOP
in0_ready  output  1  source 0 ready
in1_data / in1_empty / in1_valid / in1_startofpacket / in1_endofpacket  input  as in0  source 1 stream
in1_ready  output  1  source 1 ready
stream_out_data  output  DATA_WIDTH  to responder
stream_out_empty  output  EMPTY_WIDTH
stream_out_valid  output  1
stream_out_startofpacket  output  1
stream_out_endofpacket  output  1
stream_out_ready  input  1  backpressure from responder
stream_out_channel  output  1  index of the granted source; meaningful only while stream_out_valid=1

Behaviour:
- Registered state:
  - state ∈ {S_IDLE, S_PASS}
  - sel (1 bit)
  - last_grant (1 bit)
- Reset (reset_n=0 at a clk edge):
  - state=S_IDLE, sel=0, last_grant=1, so source 0 wins the first tie.
  - Reset mid-packet aborts the packet with no flush; the partial packet is the upstream/responder's problem.
- Outputs are combinational from state/sel and inputs. While in S_IDLE (including after reset):
  - stream_out_valid=0, in0_ready=0, in1_ready=0
  - stream_out_data=0, stream_out_empty=0, stream_out_startofpacket=0, stream_out_endofpacket=0, stream_out_channel=0
- S_IDLE arbitration:
  - Only in0_valid=1: sel<=0, go to S_PASS.
  - Only in1_valid=1: sel<=1, go to S_PASS.
  - Both valid: sel<=~last_grant, go to S_PASS.
  - Neither valid: stay in S_IDLE.
  - Arbitration costs exactly one cycle: first beat is forwarded no earlier than the cycle after valid is seen in S_IDLE.
- S_PASS:
  - stream_out_{data,empty,valid,startofpacket,endofpacket} = in<sel>_*.
  - stream_out_channel=sel.
  - in<sel>_ready=stream_out_ready; the other in*_ready=0.
  - Zero-latency pass-through; no buffering.
- Beat accepted = stream_out_valid && stream_out_ready.
  - Accepted beat with stream_out_endofpacket=1: state<=S_IDLE, last_grant<=sel.
  - One idle bubble cycle always separates consecutive packets.
  - Single-beat packets (SOP=EOP=1) are legal.
- startofpacket is not checked; the grant is issued on valid alone. A source presenting valid without SOP is forwarded as-is.
- Non-selected source is held off (ready=0) for the full packet regardless of its valid.
- stream_out_ready may drop at any beat; data/valid simply hold at the source per Avalon-ST (readyLatency=0).
- Valid deasserting mid-packet keeps the grant (no timeout); the arbiter waits in S_PASS.

Optional Feature:
- Macro ICMP_ARB_STATS_EN.
- When defined, adds:
  - Outputs pkt_count0 and pkt_count1, each 16 bits, registered.
  - Each counter increments by 1 on every accepted EOP beat from its source.
  - Counters wrap from 16'hFFFF to 0 and are cleared by reset.
  - Output arb_conflict, 1 bit, registered: pulses high for exactly one cycle the cycle after S_IDLE saw both inputs valid.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then in0 sends 3-beat packet (0x11111111, 0x22222222, 0x33333333, empty=2 on last), stream_out_ready=1 -> out beats identical in order, channel=0, SOP on beat 1, EOP+empty=2 on beat 3, in1_ready=0 throughout.
- Both sources valid in the same cycle after reset with 2-beat packets -> in0 packet first, 1 idle cycle, then in1 packet (channel=1); repeat with both valid -> in0 again (alternation).
- in1 single-beat packet (SOP=EOP=1, data 0xDEADBEEF) while in0 idle -> forwarded the cycle after valid, then state back to S_IDLE; next tie goes to in0.
- stream_out_ready toggles 1,0,0,1 during an in0 4-beat packet -> in0_ready mirrors stream_out_ready, no beat duplicated or lost, in1 held off until in0 EOP accepted.
- reset_n asserted low for 1 cycle during beat 2 of an in1 packet -> next cycle valid=0, both readies=0; afterwards a tie grants in0.
- (ICMP_ARB_STATS_EN) 3 packets from in0, 2 from in1, one tie -> pkt_count0=3, pkt_count1=2, arb_conflict pulsed exactly once.

Source files
------------

// File: rtl/icmp_stream_arbiter.sv
// Packet-granular 2:1 round-robin arbiter in front of icmp_reply stream_in: one arbitration cycle, then zero-latency pass-through.
// stream_out_ready reaches only the granted source; the other is held off until its EOP. Optional stats: ICMP_ARB_STATS_EN.
module icmp_stream_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int EMPTY_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [DATA_WIDTH-1:0]  in0_data,
   input  logic [EMPTY_WIDTH-1:0] in0_empty,
   input  logic                   in0_valid,
   input  logic                   in0_startofpacket,
   input  logic                   in0_endofpacket,
   output logic                   in0_ready,
   input  logic [DATA_WIDTH-1:0]  in1_data,
   input  logic [EMPTY_WIDTH-1:0] in1_empty,
   input  logic                   in1_valid,
   input  logic                   in1_startofpacket,
   input  logic                   in1_endofpacket,
   output logic                   in1_ready,
   output logic [DATA_WIDTH-1:0]  stream_out_data,
   output logic [EMPTY_WIDTH-1:0] stream_out_empty,
   output logic                   stream_out_valid,
   output logic                   stream_out_startofpacket,
   output logic                   stream_out_endofpacket,
   input  logic                   stream_out_ready,
   output logic                   stream_out_channel
`ifdef ICMP_ARB_STATS_EN
   ,
   output logic [15:0]            pkt_count0,
   output logic [15:0]            pkt_count1,
   output logic                   arb_conflict
`endif
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  data;
      logic [EMPTY_WIDTH-1:0] empty;
      logic                   sop;
      logic                   eop;
   } beat_t;

   typedef enum logic {S_IDLE, S_PASS} state_t;

   state_t state;
   logic   sel;
   logic   last_grant;

   beat_t  beat0;
   beat_t  beat1;
   beat_t  cur_beat;
   logic   cur_valid;
   logic   accept_eop;

   assign beat0     = {in0_data, in0_empty, in0_startofpacket, in0_endofpacket};
   assign beat1     = {in1_data, in1_empty, in1_startofpacket, in1_endofpacket};
   assign cur_beat  = sel ? beat1 : beat0;
   assign cur_valid = sel ? in1_valid : in0_valid;

   assign accept_eop = (state == S_PASS) && cur_valid && stream_out_ready && cur_beat.eop;

   // Idle drives everything to zero so the responder never sees stale data.
   always_comb begin
      stream_out_data          = '0;
      stream_out_empty         = '0;
      stream_out_valid         = 1'b0;
      stream_out_startofpacket = 1'b0;
      stream_out_endofpacket   = 1'b0;
      stream_out_channel       = 1'b0;
      in0_ready                = 1'b0;
      in1_ready                = 1'b0;
      if (state == S_PASS) begin
         stream_out_data          = cur_beat.data;
         stream_out_empty         = cur_beat.empty;
         stream_out_valid         = cur_valid;
         stream_out_startofpacket = cur_beat.sop;
         stream_out_endofpacket   = cur_beat.eop;
         stream_out_channel       = sel;
         in0_ready                = ~sel & stream_out_ready;
         in1_ready                = sel & stream_out_ready;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         sel        <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (in0_valid && in1_valid) begin
                  sel   <= ~last_grant;
                  state <= S_PASS;
               end else if (in0_valid) begin
                  sel   <= 1'b0;
                  state <= S_PASS;
               end else if (in1_valid) begin
                  sel   <= 1'b1;
                  state <= S_PASS;
               end
            end
            S_PASS: begin
               if (accept_eop) begin
                  state      <= S_IDLE;
                  last_grant <= sel;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ICMP_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pkt_count0   <= '0;
         pkt_count1   <= '0;
         arb_conflict <= 1'b0;
      end else begin
         arb_conflict <= (state == S_IDLE) && in0_valid && in1_valid;
         if (accept_eop && !sel) pkt_count0 <= pkt_count0 + 16'd1;
         if (accept_eop && sel)  pkt_count1 <= pkt_count1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icmp_stream_arbiter.sv
// Directed bench for icmp_stream_arbiter; stats checks are compiled in with ICMP_ARB_STATS_EN.
module tb_icmp_stream_arbiter;

   localparam int DW = 32;
   localparam int EW = 2;
   localparam int OW = DW + EW + 6;
   localparam logic [OW-1:0] IDLE_V = '0;

   logic          clk;
   logic          reset_n;
   logic [DW-1:0] in0_data, in1_data, stream_out_data;
   logic [EW-1:0] in0_empty, in1_empty, stream_out_empty;
   logic          in0_valid, in0_startofpacket, in0_endofpacket, in0_ready;
   logic          in1_valid, in1_startofpacket, in1_endofpacket, in1_ready;
   logic          stream_out_valid, stream_out_startofpacket, stream_out_endofpacket;
   logic          stream_out_ready, stream_out_channel;
`ifdef ICMP_ARB_STATS_EN
   logic [15:0]   pkt_count0, pkt_count1;
   logic          arb_conflict;
   int            conf_cnt;
`endif

   int            total;
   int            bad;
   logic [OW-1:0] want;

   icmp_stream_arbiter #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .in0_data                 (in0_data),
      .in0_empty                (in0_empty),
      .in0_valid                (in0_valid),
      .in0_startofpacket        (in0_startofpacket),
      .in0_endofpacket          (in0_endofpacket),
      .in0_ready                (in0_ready),
      .in1_data                 (in1_data),
      .in1_empty                (in1_empty),
      .in1_valid                (in1_valid),
      .in1_startofpacket        (in1_startofpacket),
      .in1_endofpacket          (in1_endofpacket),
      .in1_ready                (in1_ready),
      .stream_out_data          (stream_out_data),
      .stream_out_empty         (stream_out_empty),
      .stream_out_valid         (stream_out_valid),
      .stream_out_startofpacket (stream_out_startofpacket),
      .stream_out_endofpacket   (stream_out_endofpacket),
      .stream_out_ready         (stream_out_ready),
      .stream_out_channel       (stream_out_channel)
`ifdef ICMP_ARB_STATS_EN
      ,
      .pkt_count0               (pkt_count0),
      .pkt_count1               (pkt_count1),
      .arb_conflict             (arb_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [OW-1:0] obs();
      return {stream_out_valid, stream_out_startofpacket, stream_out_endofpacket,
              stream_out_empty, stream_out_channel, stream_out_data, in0_ready, in1_ready};
   endfunction

   function automatic logic [OW-1:0] ev(input logic v, input logic s, input logic e,
                                        input logic [EW-1:0] emp, input logic ch,
                                        input logic [DW-1:0] d, input logic r0, input logic r1);
      return {v, s, e, emp, ch, d, r0, r1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int src, input logic v, input logic sop, input logic eop,
                      input logic [EW-1:0] emp, input logic [DW-1:0] d);
      if (src == 0) begin
         in0_valid = v; in0_startofpacket = sop; in0_endofpacket = eop;
         in0_empty = emp; in0_data = d;
      end else begin
         in1_valid = v; in1_startofpacket = sop; in1_endofpacket = eop;
         in1_empty = emp; in1_data = d;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      stream_out_ready = 1'b1;
      drv(0, 1, 1, 0, 0, 32'h01010101);
      drv(1, 1, 1, 0, 0, 32'h02020202);
      tick();
      tick();
      @(negedge clk);
      want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL reset_held got=%h want=%h", obs(), want); end
`ifdef ICMP_ARB_STATS_EN
      total++;
      if ({pkt_count0, pkt_count1, arb_conflict} !== 33'd0) begin
         bad++; $display("FAIL reset_stats got=%h want=0", {pkt_count0, pkt_count1, arb_conflict});
      end
`endif
      tick();
      reset_n = 1'b1;
      drv(0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL reset_idle got=%h want=%h", obs(), want); end
      tick();
   endtask

   task automatic test_single_packet();
      drv(0, 1, 1, 0, 0, 32'h11111111);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL single_arb got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 0, 0, 0, 32'h11111111, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL single_b1 got=%h want=%h", obs(), want); end
      tick(); drv(0, 1, 0, 0, 0, 32'h22222222);
      @(negedge clk); want = ev(1, 0, 0, 0, 0, 32'h22222222, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL single_b2 got=%h want=%h", obs(), want); end
      tick(); drv(0, 1, 0, 1, 2, 32'h33333333);
      @(negedge clk); want = ev(1, 0, 1, 2, 0, 32'h33333333, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL single_b3 got=%h want=%h", obs(), want); end
      tick(); drv(0, 0, 0, 0, 0, 0);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL single_done got=%h want=%h", obs(), want); end
      tick();
   endtask

   task automatic test_tie_alternation();
      do_reset();
      drv(0, 1, 1, 0, 0, 32'hA0000001);
      drv(1, 1, 1, 0, 0, 32'hB0000001);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL tie_arb got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 0, 0, 0, 32'hA0000001, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL tie_a0 got=%h want=%h", obs(), want); end
      tick(); drv(0, 1, 0, 1, 1, 32'hA0000002);
      @(negedge clk); want = ev(1, 0, 1, 1, 0, 32'hA0000002, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL tie_a1 got=%h want=%h", obs(), want); end
      tick(); drv(0, 0, 0, 0, 0, 0);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL tie_bubble got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 0, 0, 1, 32'hB0000001, 0, 1); total++;
      if (obs() !== want) begin bad++; $display("FAIL tie_b0 got=%h want=%h", obs(), want); end
      tick(); drv(1, 1, 0, 1, 3, 32'hB0000002);
      @(negedge clk); want = ev(1, 0, 1, 3, 1, 32'hB0000002, 0, 1); total++;
      if (obs() !== want) begin bad++; $display("FAIL tie_b1 got=%h want=%h", obs(), want); end
      // second tie must alternate back to source 0
      tick();
      drv(0, 1, 1, 0, 0, 32'hA0000001);
      drv(1, 1, 1, 0, 0, 32'hB0000001);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL tie2_arb got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 0, 0, 0, 32'hA0000001, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL tie2_a0 got=%h want=%h", obs(), want); end
      tick(); drv(0, 1, 0, 1, 1, 32'hA0000002);
      @(negedge clk); want = ev(1, 0, 1, 1, 0, 32'hA0000002, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL tie2_a1 got=%h want=%h", obs(), want); end
      tick(); drv(0, 0, 0, 0, 0, 0);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL tie2_bubble got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 0, 0, 1, 32'hB0000001, 0, 1); total++;
      if (obs() !== want) begin bad++; $display("FAIL tie2_b0 got=%h want=%h", obs(), want); end
      tick(); drv(1, 1, 0, 1, 3, 32'hB0000002);
      @(negedge clk); want = ev(1, 0, 1, 3, 1, 32'hB0000002, 0, 1); total++;
      if (obs() !== want) begin bad++; $display("FAIL tie2_b1 got=%h want=%h", obs(), want); end
      tick(); drv(1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_single_beat();
      drv(1, 1, 1, 1, 0, 32'hDEADBEEF);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL sb_arb got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 1, 0, 1, 32'hDEADBEEF, 0, 1); total++;
      if (obs() !== want) begin bad++; $display("FAIL sb_beat got=%h want=%h", obs(), want); end
      tick(); drv(1, 0, 0, 0, 0, 0);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL sb_idle got=%h want=%h", obs(), want); end
      tick();
      drv(0, 1, 1, 1, 0, 32'hC0C0C0C0);
      drv(1, 1, 1, 1, 0, 32'hDEADBEEF);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL sb_tie_arb got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 1, 0, 0, 32'hC0C0C0C0, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL sb_tie_in0 got=%h want=%h", obs(), want); end
      tick(); drv(0, 0, 0, 0, 0, 0);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL sb_bubble got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 1, 0, 1, 32'hDEADBEEF, 0, 1); total++;
      if (obs() !== want) begin bad++; $display("FAIL sb_tie_in1 got=%h want=%h", obs(), want); end
      tick(); drv(1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_backpressure();
      drv(0, 1, 1, 0, 0, 32'hD0000000);
      drv(1, 1, 1, 1, 0, 32'hE0E0E0E0);
      stream_out_ready = 1'b1;
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL bp_arb got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 0, 0, 0, 32'hD0000000, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL bp_d0 got=%h want=%h", obs(), want); end
      tick(); drv(0, 1, 0, 0, 0, 32'hD0000001); stream_out_ready = 1'b0;
      @(negedge clk); want = ev(1, 0, 0, 0, 0, 32'hD0000001, 0, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL bp_stall1 got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 0, 0, 0, 0, 32'hD0000001, 0, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL bp_stall2 got=%h want=%h", obs(), want); end
      tick(); stream_out_ready = 1'b1;
      @(negedge clk); want = ev(1, 0, 0, 0, 0, 32'hD0000001, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL bp_d1 got=%h want=%h", obs(), want); end
      tick(); drv(0, 1, 0, 0, 0, 32'hD0000002);
      @(negedge clk); want = ev(1, 0, 0, 0, 0, 32'hD0000002, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL bp_d2 got=%h want=%h", obs(), want); end
      tick(); drv(0, 1, 0, 1, 0, 32'hD0000003);
      @(negedge clk); want = ev(1, 0, 1, 0, 0, 32'hD0000003, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL bp_d3 got=%h want=%h", obs(), want); end
      tick(); drv(0, 0, 0, 0, 0, 0);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL bp_bubble got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 1, 0, 1, 32'hE0E0E0E0, 0, 1); total++;
      if (obs() !== want) begin bad++; $display("FAIL bp_in1 got=%h want=%h", obs(), want); end
      tick(); drv(1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_packet();
      drv(1, 1, 1, 0, 0, 32'hF0000000);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL rmp_arb got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 0, 0, 1, 32'hF0000000, 0, 1); total++;
      if (obs() !== want) begin bad++; $display("FAIL rmp_f0 got=%h want=%h", obs(), want); end
      tick(); drv(1, 1, 0, 0, 0, 32'hF0000001); reset_n = 1'b0;
      @(negedge clk); want = ev(1, 0, 0, 0, 1, 32'hF0000001, 0, 1); total++;
      if (obs() !== want) begin bad++; $display("FAIL rmp_f1 got=%h want=%h", obs(), want); end
      tick(); reset_n = 1'b1; drv(0, 1, 1, 1, 0, 32'h60606060);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL rmp_after got=%h want=%h", obs(), want); end
      tick();
      @(negedge clk); want = ev(1, 1, 1, 0, 0, 32'h60606060, 1, 0); total++;
      if (obs() !== want) begin bad++; $display("FAIL rmp_tie_in0 got=%h want=%h", obs(), want); end
      tick(); drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
      @(negedge clk); want = IDLE_V; total++;
      if (obs() !== want) begin bad++; $display("FAIL rmp_end got=%h want=%h", obs(), want); end
      tick();
   endtask

`ifdef ICMP_ARB_STATS_EN
   task automatic run_src(input int n0, input int n1);
      int  rem0, rem1;
      logic a0, a1;
      rem0 = n0;
      rem1 = n1;
      for (int c = 0; c < 10; c++) begin
         drv(0, rem0 > 0, 1, 1, 0, 32'h0000AAAA);
         drv(1, rem1 > 0, 1, 1, 0, 32'h0000BBBB);
         @(negedge clk);
         if (arb_conflict === 1'b1) conf_cnt++;
         a0 = in0_valid & in0_ready;
         a1 = in1_valid & in1_ready;
         tick();
         if (a0) rem0--;
         if (a1) rem1--;
      end
      drv(0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_stats();
      do_reset();
      conf_cnt = 0;
      run_src(1, 1);
      run_src(2, 0);
      run_src(0, 1);
      total++;
      if (pkt_count0 !== 16'd3) begin bad++; $display("FAIL stats_cnt0 got=%0d want=3", pkt_count0); end
      total++;
      if (pkt_count1 !== 16'd2) begin bad++; $display("FAIL stats_cnt1 got=%0d want=2", pkt_count1); end
      total++;
      if (conf_cnt !== 1) begin bad++; $display("FAIL stats_conflict pulses=%0d want=1", conf_cnt); end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      reset_n = 1'b0;
      stream_out_ready = 1'b1;
      drv(0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0);
      test_reset();
      test_single_packet();
      test_tie_alternation();
      test_single_beat();
      test_backpressure();
      test_reset_mid_packet();
`ifdef ICMP_ARB_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
